// File: rtl/wb_sram_pkg.sv
// Shared types and constants for the Wishbone-to-async-SRAM bridge.
package wb_sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LANE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    ACK,
    TURN
  } state_e;

  localparam int NUM_LANES = 4;
  localparam int SR_AW     = 17;
  localparam int WR_PHASES = 3;

  // Lowest selected lane at or above 'from'; bit 2 set means none left.
  function automatic logic [2:0] next_lane(input logic [3:0] sel, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b100;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (sel[i] && (3'(i) >= from)) r = {1'b0, 2'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_sram_io.sv
// Tristate pad wrapper for the 8-bit SRAM data bus.
module wb_sram_io (
  input  logic       i_oe,
  input  logic [7:0] i_dout,
  output logic [7:0] o_din,
  inout  wire  [7:0] io_pad
);

  assign io_pad = i_oe ? i_dout : 8'hzz;
  assign o_din  = io_pad;

endmodule

// File: rtl/wb_sram.sv
// Wishbone classic slave: each 32-bit transfer becomes ascending byte
// accesses on an external 128K x 8 asynchronous SRAM.
module wb_sram
  import wb_sram_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  output logic              ack_o,
  input  logic [SR_AW-1:0]  adr_i,
  input  logic [31:0]       dat_i,
  output logic [31:0]       dat_o,
  input  logic [3:0]        sel_i,
  output logic              sr_cs,
  output logic              sr_we,
  output logic              sr_oe,
  output logic [SR_AW-1:0]  sr_adr,
  inout  wire  [7:0]        sr_dio
);

  localparam int CW = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;

  state_e           r_state, w_next;
  logic [1:0]       r_lane;
  logic [CW-1:0]    r_cnt;
  logic [SR_AW-3:0] r_adr_hi;
  logic [31:0]      r_wdat;
  logic [3:0]       r_sel;
  logic [23:0]      r_rbuf;
  logic [31:0]      r_dat;

  logic       w_req, w_lane_end, w_dio_oe;
  logic [2:0] w_first, w_after;
  logic [7:0] w_din, w_dout;
  logic       w_unused;

  assign w_req      = cyc_i & stb_i;
  assign w_first    = next_lane(sel_i, 3'd0);
  assign w_after    = next_lane(r_sel, {1'b0, r_lane} + 3'd1);
  assign w_lane_end = (r_cnt == CW'(ACCESS_CYCLES - 1));
  assign w_dout     = r_wdat[{r_lane, 3'b000} +: 8];
  assign w_unused   = ^adr_i[1:0];

  assign sr_adr = {r_adr_hi, r_lane};
  assign dat_o  = r_dat;

  wb_sram_io u_io (
    .i_oe   (w_dio_oe),
    .i_dout (w_dout),
    .o_din  (w_din),
    .io_pad (sr_dio)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    sr_cs    = 1'b1;
    sr_we    = 1'b1;
    sr_oe    = 1'b1;
    ack_o    = 1'b0;
    w_dio_oe = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (!we_i)           w_next = RD_LANE;
          else if (w_first[2]) w_next = ACK;
          else                 w_next = WR_SETUP;
        end
      end
      RD_LANE: begin
        sr_cs = 1'b0;
        sr_oe = 1'b0;
        if (w_lane_end && (r_lane == 2'd3)) w_next = ACK;
      end
      WR_SETUP: begin
        sr_cs    = 1'b0;
        w_dio_oe = 1'b1;
        w_next   = WR_PULSE;
      end
      WR_PULSE: begin
        sr_cs    = 1'b0;
        sr_we    = 1'b0;
        w_dio_oe = 1'b1;
        w_next   = WR_HOLD;
      end
      WR_HOLD: begin
        sr_cs    = 1'b0;
        w_dio_oe = 1'b1;
        w_next   = w_after[2] ? ACK : WR_SETUP;
      end
      ACK: begin
        ack_o  = 1'b1;
        w_next = TURN;
      end
      TURN:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lane   <= '0;
      r_cnt    <= '0;
      r_adr_hi <= '0;
      r_wdat   <= '0;
      r_sel    <= '0;
      r_rbuf   <= '0;
      r_dat    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_cnt  <= '0;
            r_wdat <= dat_i;
            r_sel  <= sel_i;
            // An empty write leaves the SRAM address untouched.
            if (!we_i) begin
              r_adr_hi <= adr_i[SR_AW-1:2];
              r_lane   <= 2'd0;
            end else if (!w_first[2]) begin
              r_adr_hi <= adr_i[SR_AW-1:2];
              r_lane   <= w_first[1:0];
            end
          end
        end
        RD_LANE: begin
          if (w_lane_end) begin
            r_cnt <= '0;
            // dat_o only changes once the whole word is in.
            case (r_lane)
              2'd0: r_rbuf[7:0]   <= w_din;
              2'd1: r_rbuf[15:8]  <= w_din;
              2'd2: r_rbuf[23:16] <= w_din;
              default: r_dat      <= {w_din, r_rbuf};
            endcase
            if (r_lane != 2'd3) r_lane <= r_lane + 2'd1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        WR_HOLD: begin
          if (!w_after[2]) r_lane <= w_after[1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram.sv
// Scoreboard bench for wb_sram against a behavioural 128K x 8 SRAM model.
module tb_wb_sram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [16:0] adr_i = '0;
  logic [31:0] dat_i = '0;
  logic [3:0]  sel_i = '0;
  wire         ack_o, sr_cs, sr_we, sr_oe;
  wire  [31:0] dat_o;
  wire  [16:0] sr_adr;
  wire  [7:0]  sr_dio;

  always #10 clk = ~clk;

  wb_sram #(.ACCESS_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .ack_o(ack_o), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .sel_i(sel_i),
    .sr_cs(sr_cs), .sr_we(sr_we), .sr_oe(sr_oe), .sr_adr(sr_adr), .sr_dio(sr_dio)
  );

  typedef struct { logic is_rd; logic [31:0] data; } exp_ack_t;
  typedef struct { logic [16:0] adr; logic [7:0] data; } exp_wr_t;

  int          vectors = 0, miscompares = 0, acks = 0;
  exp_ack_t    ack_q[$];
  exp_wr_t     wr_q[$];
  logic [16:0] trace[$];
  logic [31:0] last_rd = '0;
  logic        const_mode = 1'b1;
  logic [7:0]  mem [0:131071];
  logic [7:0]  m_byte;
  logic        m_drv;

  // SRAM model drives only when selected for a read.
  assign m_drv = !sr_cs && !sr_oe && sr_we;
  always_comb m_byte = const_mode ? 8'hAD : mem[sr_adr];
  assign sr_dio = m_drv ? m_byte : 8'hzz;

  always @(negedge clk) begin
    if (rst) begin
      if (!sr_cs) trace.push_back(sr_adr);
      if (!sr_cs && !sr_we) begin
        vectors++;
        if (wr_q.size() == 0) begin
          miscompares++;
          $display("FAIL wr_pulse unexpected adr=%h data=%h", sr_adr, sr_dio);
        end else begin
          exp_wr_t e;
          e = wr_q.pop_front();
          if ({sr_adr, sr_dio, sr_oe} !== {e.adr, e.data, 1'b1}) begin
            miscompares++;
            $display("FAIL wr_pulse got adr=%h data=%h oe=%b want adr=%h data=%h oe=1",
                     sr_adr, sr_dio, sr_oe, e.adr, e.data);
          end
        end
        mem[sr_adr] = sr_dio;
      end
      if (ack_o) begin
        acks++;
        vectors++;
        if (ack_q.size() == 0) begin
          miscompares++;
          $display("FAIL ack unexpected dat_o=%h", dat_o);
        end else begin
          exp_ack_t e;
          e = ack_q.pop_front();
          if (dat_o !== e.data) begin
            miscompares++;
            $display("FAIL ack_dat_o rd=%b got %h want %h", e.is_rd, dat_o, e.data);
          end
        end
      end
    end
  end

  task automatic xfer(input logic we, input logic [16:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output int lat);
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
    @(posedge clk);
    #1;
    cyc_i = 1'b0; stb_i = 1'b0; dat_i = '0; sel_i = '0;
    lat = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ack_o) begin lat = i; break; end
    end
    @(negedge clk);
    vectors++;
    if (ack_o !== 1'b0 || lat < 0) begin
      miscompares++;
      $display("FAIL ack_pulse lat=%0d ack_after=%b want single pulse", lat, ack_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #5;
    vectors++;
    if ({ack_o, sr_cs, sr_we, sr_oe, sr_adr, dat_o, u_dut.u_io.i_oe} !==
        {1'b0, 3'b111, 17'h0, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state ack=%b cs=%b we=%b oe=%b adr=%h dat=%h dio_oe=%b",
               ack_o, sr_cs, sr_we, sr_oe, sr_adr, dat_o, u_dut.u_io.i_oe);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read();
    int lat;
    trace.delete();
    const_mode = 1'b1;
    ack_q.push_back('{1'b1, 32'hADADADAD});
    last_rd = 32'hADADADAD;
    xfer(1'b0, 17'h5500, 32'h0, 4'h0, lat);
    vectors++;
    if (lat !== 8) begin
      miscompares++;
      $display("FAIL read_latency got %0d want 8", lat);
    end
    vectors++;
    if (trace.size() != 8) begin
      miscompares++;
      $display("FAIL read_trace_len got %0d want 8", trace.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        vectors++;
        if (trace[k] !== 17'h5500 + 17'(k / 2)) begin
          miscompares++;
          $display("FAIL read_adr[%0d] got %h want %h", k, trace[k], 17'h5500 + 17'(k / 2));
        end
      end
    end
  endtask

  task automatic test_reset_midread();
    int a0;
    a0 = acks;
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 17'h0400;
    @(posedge clk);
    #1;
    cyc_i = 1'b0; stb_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if ({ack_o, sr_cs, sr_we, sr_oe, dat_o, u_dut.u_io.i_oe} !==
        {1'b0, 3'b111, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL midread_reset ack=%b cs=%b we=%b oe=%b dat=%h dio_oe=%b",
               ack_o, sr_cs, sr_we, sr_oe, dat_o, u_dut.u_io.i_oe);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    last_rd = 32'h0;
    repeat (15) @(negedge clk);
    vectors++;
    if (acks != a0 || sr_cs !== 1'b1) begin
      miscompares++;
      $display("FAIL aborted_ack got %0d acks cs=%b want 0 acks cs=1", acks - a0, sr_cs);
    end
  endtask

  task automatic test_write_partial();
    int lat;
    trace.delete();
    wr_q.push_back('{17'hAA00, 8'hEF});
    wr_q.push_back('{17'hAA02, 8'hAD});
    wr_q.push_back('{17'hAA03, 8'hDE});
    ack_q.push_back('{1'b0, last_rd});
    xfer(1'b1, 17'hAA00, 32'hDEADBEEF, 4'b1101, lat);
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL write_latency got %0d want 9", lat);
    end
    vectors++;
    if (trace.size() != 9 || wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL write_trace len=%0d pending=%0d want 9 and 0", trace.size(), wr_q.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        logic [16:0] w;
        w = (k < 3) ? 17'hAA00 : (k < 6) ? 17'hAA02 : 17'hAA03;
        vectors++;
        if (trace[k] !== w) begin
          miscompares++;
          $display("FAIL write_adr[%0d] got %h want %h", k, trace[k], w);
        end
      end
    end
  endtask

  task automatic test_write_none();
    int lat;
    trace.delete();
    ack_q.push_back('{1'b0, last_rd});
    xfer(1'b1, 17'h1234, 32'hFFFFFFFF, 4'b0000, lat);
    vectors++;
    if (lat !== 0 || trace.size() != 0) begin
      miscompares++;
      $display("FAIL write_none lat=%0d cs_cycles=%0d want 0 and 0", lat, trace.size());
    end
  endtask

  task automatic test_back_to_back();
    int a0, n, first, second;
    a0 = acks; n = 0; first = -1; second = -1;
    const_mode = 1'b1;
    ack_q.push_back('{1'b1, 32'hADADADAD});
    ack_q.push_back('{1'b1, 32'hADADADAD});
    last_rd = 32'hADADADAD;
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 17'h0800;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ack_o) begin
        n++;
        if (n == 1) first = i;
        else begin second = i; cyc_i = 1'b0; stb_i = 1'b0; break; end
      end
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    vectors++;
    if (second - first !== 11 || first < 0) begin
      miscompares++;
      $display("FAIL b2b_spacing got %0d want 11 (first=%0d)", second - first, first);
    end
    repeat (20) @(negedge clk);
    vectors++;
    if (acks - a0 != 2) begin
      miscompares++;
      $display("FAIL b2b_ack_count got %0d want 2", acks - a0);
    end
  endtask

  task automatic test_readback();
    int lat;
    const_mode = 1'b0;
    wr_q.push_back('{17'h0100, 8'h78});
    wr_q.push_back('{17'h0101, 8'h56});
    wr_q.push_back('{17'h0102, 8'h34});
    wr_q.push_back('{17'h0103, 8'h12});
    ack_q.push_back('{1'b0, last_rd});
    xfer(1'b1, 17'h0100, 32'h12345678, 4'hF, lat);
    vectors++;
    if (lat !== 12) begin
      miscompares++;
      $display("FAIL readback_wr_latency got %0d want 12", lat);
    end
    ack_q.push_back('{1'b1, 32'h12345678});
    last_rd = 32'h12345678;
    xfer(1'b0, 17'h0100, 32'h0, 4'h0, lat);
    vectors++;
    if (dat_o !== 32'h12345678) begin
      miscompares++;
      $display("FAIL readback_hold got %h want 12345678", dat_o);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_reset_midread();
    test_write_partial();
    test_write_none();
    test_read();
    test_back_to_back();
    test_readback();
    vectors++;
    if (ack_q.size() != 0 || wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain acks_left=%0d writes_left=%0d want 0", ack_q.size(), wr_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
